rf_2p_rd_ctrl: RTL and testbench

Read-side controller for the two-port byte-enable register file. Given a base address and word count, it drives the RAM's read port (low-active chip enable, 1-cycle registered read latency) and turns the returned words into a valid/ready stream. A 2-entry skid FIFO absorbs the RAM latency, so the block sustains one word per cycle under continuous `rdy_i`. It sits between a line-buffer RAM and the downstream consumer, for example the pixel fetch of a prediction or filter engine.

---
 rtl/rf_2p_rd_ctrl.sv | 128 ++++++++++++
 tb/tb_rf_2p_rd_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_2p_rd_ctrl.sv
// Read-side controller for the two-port register file: issues RAM reads for a
// base/length request and delivers the returned words as a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | issuing reads, gated by FIFO credit
// DRAIN | all reads issued, waiting for the stream to accept the tail
module rf_2p_rd_ctrl #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8,
  parameter int Len_Width  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [Addr_Width-1:0] base_addr_i,
  input  logic [Len_Width-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cena_o,
  output logic [Addr_Width-1:0] addra_o,
  input  logic [Word_Width-1:0] dataa_i,
  output logic [Word_Width-1:0] data_o,
  output logic                  val_o,
  input  logic                  rdy_i
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [Len_Width-1:0]  issue_cnt_q, issue_cnt_d;
  logic [Len_Width-1:0]  acc_cnt_q, acc_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [Word_Width-1:0] mem_q [2];
  logic                  cena_d, busy_d, done_d;
  logic [Addr_Width-1:0] addra_d;
  logic                  push, pop, issue;
  logic [2:0]            occ;

  assign val_o  = (count_q != 2'd0);
  assign data_o = mem_q[rd_ptr_q];

  always_comb begin
    pop  = val_o & rdy_i;
    // A full FIFO leaves the returned word parked on the RAM output, which holds
    // while cena_o stays high; the credit rule never issues a read over it.
    push = inflight_q & ((count_q != 2'd2) | pop);
    occ  = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    inflight_d  = ~cena_o | (inflight_q & ~push);
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    acc_cnt_d   = acc_cnt_q - Len_Width'(pop);
    issue       = 1'b0;
    cena_d      = 1'b1;
    addra_d     = addra_o;
    busy_d      = busy_o;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d     = READ;
            cena_d      = 1'b0;
            addra_d     = base_addr_i;
            issue_cnt_d = len_i - Len_Width'(1);
            acc_cnt_d   = len_i;
            busy_d      = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        issue = (issue_cnt_q != '0) && (occ < 3'd2);
        if (issue) begin
          cena_d      = 1'b0;
          addra_d     = addra_o + Addr_Width'(1);
          issue_cnt_d = issue_cnt_q - Len_Width'(1);
        end
        if (issue_cnt_d == '0) state_d = DRAIN;
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && pop && acc_cnt_q == Len_Width'(1)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      cena_o      <= 1'b1;
      addra_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= dataa_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cena_o  <= cena_d;
      addra_o <= addra_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

endmodule

// File: tb/tb_rf_2p_rd_ctrl.sv
// Bench for rf_2p_rd_ctrl: queue-based model of reads/stream/completion checked
// every cycle, plus cycle-exact literal checks for the documented scenarios.
module tb_rf_2p_rd_ctrl;
  localparam int WW = 32, AW = 8, LW = 9;

  logic          clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, cena_o, val_o;
  logic [AW-1:0] addra_o;
  logic [WW-1:0] dataa_i = '0, data_o;
  logic          rdy_i = 1'b1;
  bit            rnd_rdy = 1'b0, rdy_fix = 1'b1;

  logic [WW-1:0] ram [256];
  int checks = 0, failures = 0;

  rf_2p_rd_ctrl #(.Word_Width(WW), .Addr_Width(AW), .Len_Width(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .cena_o(cena_o),
    .addra_o(addra_o), .dataa_i(dataa_i), .data_o(data_o), .val_o(val_o),
    .rdy_i(rdy_i));

  always #5 clk = ~clk;

  // RAM read port: registered read, output holds while not enabled
  always @(posedge clk) if (!cena_o) dataa_i <= ram[addra_o];

  always @(posedge clk) begin
    #2;
    rdy_i = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: pending addresses, pending words, words not yet accepted
  logic [AW-1:0] m_addr[$];
  logic [WW-1:0] m_data[$];
  int  m_remaining = 0, m_out = 0;
  bit  m_busy = 0, m_done = 0;
  bit  acc, was_busy;
  logic [AW-1:0] a;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk({busy_o, done_o, cena_o, val_o, addra_o, data_o} == {4'b0010, 8'h00, 32'h0},
          "reset_values", longint'({busy_o, done_o, cena_o, val_o, addra_o, data_o}),
          longint'({4'b0010, 8'h00, 32'h0}));
      m_addr.delete(); m_data.delete();
      m_remaining = 0; m_out = 0; m_busy = 0; m_done = 0;
    end else begin
      was_busy = m_busy;
      chk(busy_o == m_busy, "busy", busy_o, m_busy);
      chk(done_o == m_done, "done", done_o, m_done);
      m_done = 0;
      if (!cena_o) begin
        if (m_addr.size() == 0) chk(1'b0, "extra_read", addra_o, 0);
        else begin
          chk(addra_o == m_addr[0], "read_addr", addra_o, m_addr[0]);
          void'(m_addr.pop_front());
        end
        m_out++;
        chk(m_out <= 3, "outstanding_bound", m_out, 3);
      end
      acc = 0;
      if (val_o) begin
        if (m_data.size() == 0) chk(1'b0, "spurious_valid", data_o, 0);
        else begin
          chk(data_o == m_data[0], "stream_data", data_o, m_data[0]);
          if (rdy_i) begin
            acc = 1;
            void'(m_data.pop_front());
            m_out--;
            m_remaining--;
          end
        end
      end
      if (acc && m_remaining == 0) begin
        chk(m_addr.size() == 0, "all_reads_issued", m_addr.size(), 0);
        m_busy = 0;
        m_done = 1;
      end
      if (start_i && !was_busy) begin
        if (len_i == '0) m_done = 1;
        else begin
          for (int k = 0; k < int'(len_i); k++) begin
            a = base_addr_i + AW'(k);
            m_addr.push_back(a);
            m_data.push_back(ram[a]);
          end
          m_remaining = int'(len_i);
          m_busy = 1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of cycle 1
  task automatic go(input logic [AW-1:0] b, input int n);
    start_i = 1'b1; base_addr_i = b; len_i = LW'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int c0, input int maxc, output int cyc);
    cyc = -1;
    for (int c = c0; c <= maxc; c++) begin
      if (done_o) begin cyc = c; break; end
      step();
    end
    if (cyc < 0) chk(1'b0, "done_timeout", maxc, 0);
  endtask

  int cena_n, done_c, nd, cyc;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = i * 32'h01010101;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Full-rate read
    go(8'h10, 8);
    cena_n = 0; done_c = -1;
    for (int c = 1; c <= 12; c++) begin
      if (!cena_o) cena_n++;
      if (c == 1) chk(busy_o && !cena_o && addra_o == 8'h10, "fr_cycle1", addra_o, 8'h10);
      if (c == 3) chk(val_o && data_o == 32'h10101010, "fr_first_word", data_o, 32'h10101010);
      if (c == 10) chk(val_o && data_o == 32'h17171717, "fr_last_word", data_o, 32'h17171717);
      if (done_o && done_c < 0) begin done_c = c; chk(!busy_o, "fr_busy_at_done", busy_o, 0); end
      step();
    end
    chk(cena_n == 8, "fr_cena_cycles", cena_n, 8);
    chk(done_c == 11, "fr_done_cycle", done_c, 11);

    // Address wrap
    go(8'hFE, 4);
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) chk(addra_o == 8'hFE, "wrap_addr0", addra_o, 8'hFE);
      if (c == 3) chk(addra_o == 8'h00, "wrap_addr2", addra_o, 8'h00);
      if (c == 4) chk(addra_o == 8'h01 && !cena_o, "wrap_addr3", addra_o, 8'h01);
      step();
    end
    wait_done(5, 40, cyc);
    chk(cyc == 7, "wrap_done_cycle", cyc, 7);
    step();

    // Back-pressure: rdy low through cycles 3..9
    go(8'h40, 6);
    cena_n = 0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) rdy_fix = 1'b0;
      if (!cena_o) cena_n++;
      if (c >= 4) chk(val_o && data_o == ram[8'h40], "bp_head_stable", data_o, ram[8'h40]);
      step();
    end
    chk(cena_n <= 3, "bp_reads_before_stall", cena_n, 3);
    rdy_fix = 1'b1;
    wait_done(10, 60, cyc);
    step();

    // Random ready, maximum length
    rnd_rdy = 1'b1;
    go(8'($urandom), 256);
    wait_done(1, 3000, cyc);
    nd = 1;
    for (int c = 0; c < 5; c++) begin step(); if (done_o) nd++; end
    chk(nd == 1, "rnd_single_done", nd, 1);
    rnd_rdy = 1'b0;

    // Zero length
    go(8'h33, 0);
    chk(done_o && cena_o && !busy_o, "len0_done_c1", {done_o, cena_o, busy_o}, 3'b110);
    step();
    chk(!done_o && cena_o, "len0_quiet_c2", {done_o, cena_o}, 2'b01);
    step();

    // Start while busy is ignored
    go(8'h20, 4);
    start_i = 1'b1; base_addr_i = 8'h80; len_i = LW'(9);
    step();
    start_i = 1'b0;
    wait_done(2, 40, cyc);
    chk(cyc == 7, "busy_start_ignored", cyc, 7);

    // Back-to-back start in the done cycle
    go(8'h30, 3);
    wait_done(1, 40, cyc);
    chk(cyc == 6, "b2b_done_cycle", cyc, 6);
    step();

    // Reset in cycle 5 of a len-16 transfer
    go(8'h00, 16);
    repeat (4) step();
    rst_n = 1'b0;
    #1 chk(cena_o && !busy_o && !val_o, "async_reset", {cena_o, busy_o, val_o}, 3'b100);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk(!val_o && cena_o, "post_reset_idle", {val_o, cena_o}, 2'b01);
      step();
    end
    go(8'h05, 2);
    wait_done(1, 40, cyc);
    chk(cyc == 5, "post_reset_len2", cyc, 5);

    // Random back-to-back transfers under random ready
    rnd_rdy = 1'b1;
    for (int t = 0; t < 8; t++) begin
      go(8'($urandom), int'($urandom_range(1, 20)));
      wait_done(1, 400, cyc);
    end
    rnd_rdy = 1'b0;
    repeat (4) step();
    chk(m_data.size() == 0 && !busy_o, "final_idle", m_data.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
